// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - request, response and RAM-side signal bundle for ram_arbiter
// Purpose: groups the CPU port, the host (loader/debug) port, the lock handshake
//   and the single-port RAM interface used by ram_arbiter.
// Ports (seen from the arbiter, modport slave):
//   cpu_req/cpu_write/cpu_addr/cpu_din    in   CPU access request
//   cpu_gnt/cpu_rvalid/cpu_dout           out  CPU grant and read return
//   host_req/host_write/host_addr/host_din in  host access request
//   host_gnt/host_rvalid/host_dout        out  host grant and read return
//   host_lock in, lock_ack out            exclusive-ownership handshake
//   ram_write/ram_addr/ram_din out, ram_dout in   RAM port
// modport master is the mirror image (requesters plus the RAM model).
interface ram_arbiter_if #(
  parameter int W      = 8,
  parameter int W_DATA = 8
);
  logic              cpu_req;
  logic              cpu_write;
  logic [W-1:0]      cpu_addr;
  logic [W_DATA-1:0] cpu_din;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [W_DATA-1:0] cpu_dout;

  logic              host_req;
  logic              host_write;
  logic [W-1:0]      host_addr;
  logic [W_DATA-1:0] host_din;
  logic              host_gnt;
  logic              host_rvalid;
  logic [W_DATA-1:0] host_dout;

  logic              host_lock;
  logic              lock_ack;

  logic              ram_write;
  logic [W-1:0]      ram_addr;
  logic [W_DATA-1:0] ram_din;
  logic [W_DATA-1:0] ram_dout;

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_din,
    output cpu_gnt, cpu_rvalid, cpu_dout,
    input  host_req, host_write, host_addr, host_din, host_lock,
    output host_gnt, host_rvalid, host_dout, lock_ack,
    output ram_write, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_din,
    input  cpu_gnt, cpu_rvalid, cpu_dout,
    output host_req, host_write, host_addr, host_din, host_lock,
    input  host_gnt, host_rvalid, host_dout, lock_ack,
    input  ram_write, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester single-port RAM arbiter with host lock
// Purpose: shares one RAM port between a CPU and a loader/debug host.
//   Round-robin between the two in RR; the host can take exclusive ownership
//   (LOCK_PEND -> LOCKED) once no CPU read is still in flight.
//   Read data returns LATENCY (1 or 2) cycles after the grant, tagged by owner.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset
//   bus  ram_arbiter_if.slave: CPU/host request ports, lock handshake, RAM port
module ram_arbiter #(
  parameter int W       = 8,
  parameter int W_DATA  = 8,
  parameter int LATENCY = 1
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {RR = 2'd0, LOCK_PEND = 2'd1, LOCKED = 2'd2} state_t;

  state_t            state;
  logic              prio_host;   // 1: host wins when both request
  logic              lock_ack_q;
  logic              cpu_gnt;
  logic              host_gnt;
  logic              rd_gnt;
  logic              cpu_pending;
  logic [W-1:0]      addr_mux;
  logic [W_DATA-1:0] din_mux;
  logic              write_mux;
  // Read-return pipeline: valid/owner per stage, owner 1 = host.
  logic              v0, h0, v1, h1;
  logic              tap_v, tap_h;

  // Any request in RR while host_lock is high already belongs to the host.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (state == RR && !bus.host_lock) begin
      if (bus.cpu_req && (!bus.host_req || !prio_host))
        cpu_gnt = 1'b1;
      else
        host_gnt = bus.host_req;
    end else begin
      host_gnt = bus.host_req;
    end
  end

  always_comb begin
    addr_mux  = '0;
    din_mux   = '0;
    write_mux = 1'b0;
    if (cpu_gnt) begin
      addr_mux  = bus.cpu_addr;
      din_mux   = bus.cpu_din;
      write_mux = bus.cpu_write;
    end else if (host_gnt) begin
      addr_mux  = bus.host_addr;
      din_mux   = bus.host_din;
      write_mux = bus.host_write;
    end
  end

  assign rd_gnt        = (cpu_gnt | host_gnt) & ~write_mux;
  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.host_gnt  = host_gnt;
  assign bus.ram_addr  = addr_mux;
  assign bus.ram_din   = din_mux;
  assign bus.ram_write = write_mux & ~rst;
  assign bus.lock_ack  = lock_ack_q;

  // A CPU read in the last stage returns this cycle, so only earlier stages
  // keep the lock pending; with LATENCY=1 there are none.
  assign cpu_pending = (LATENCY == 2) && v0 && !h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RR;
      prio_host  <= 1'b0;
      lock_ack_q <= 1'b0;
    end else begin
      case (state)
        RR: begin
          if (cpu_gnt)
            prio_host <= 1'b1;
          else if (host_gnt)
            prio_host <= 1'b0;
          lock_ack_q <= 1'b0;
          if (bus.host_lock)
            state <= LOCK_PEND;
        end
        LOCK_PEND: begin
          if (!bus.host_lock) begin
            state      <= RR;
            prio_host  <= 1'b0;
            lock_ack_q <= 1'b0;
          end else if (!cpu_pending) begin
            state      <= LOCKED;
            lock_ack_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (!bus.host_lock) begin
            state      <= RR;
            prio_host  <= 1'b0;
            lock_ack_q <= 1'b0;
          end
        end
        default: begin
          state      <= RR;
          prio_host  <= 1'b0;
          lock_ack_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      h0 <= 1'b0;
      v1 <= 1'b0;
      h1 <= 1'b0;
    end else begin
      v0 <= rd_gnt;
      h0 <= host_gnt;
      v1 <= v0;
      h1 <= h0;
    end
  end

  assign tap_v = (LATENCY == 2) ? v1 : v0;
  assign tap_h = (LATENCY == 2) ? h1 : h0;

  assign bus.cpu_rvalid  = tap_v & ~tap_h;
  assign bus.host_rvalid = tap_v & tap_h;
  assign bus.cpu_dout    = (tap_v & ~tap_h) ? bus.ram_dout : '0;
  assign bus.host_dout   = (tap_v & tap_h)  ? bus.ram_dout : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter at LATENCY 1 and 2
module tb_ram_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;

  // Index 0: LATENCY=1 instance, index 1: LATENCY=2 instance.
  logic       rst_v  [2];
  logic       c_req  [2];
  logic       c_wr   [2];
  logic [7:0] c_addr [2];
  logic [7:0] c_din  [2];
  logic       h_req  [2];
  logic       h_wr   [2];
  logic [7:0] h_addr [2];
  logic [7:0] h_din  [2];
  logic       h_lock [2];

  logic       o_cg [2];
  logic       o_hg [2];
  logic       o_cv [2];
  logic       o_hv [2];
  logic [7:0] o_cd [2];
  logic [7:0] o_hd [2];
  logic       o_la [2];
  logic       o_rw [2];
  logic [7:0] o_ra [2];

  ram_arbiter_if #(.W(8), .W_DATA(8)) b0 ();
  ram_arbiter_if #(.W(8), .W_DATA(8)) b1 ();

  ram_arbiter #(.W(8), .W_DATA(8), .LATENCY(1)) dut0 (.clk(clk), .rst(rst_v[0]), .bus(b0.slave));
  ram_arbiter #(.W(8), .W_DATA(8), .LATENCY(2)) dut1 (.clk(clk), .rst(rst_v[1]), .bus(b1.slave));

  assign b0.cpu_req = c_req[0];   assign b1.cpu_req = c_req[1];
  assign b0.cpu_write = c_wr[0];  assign b1.cpu_write = c_wr[1];
  assign b0.cpu_addr = c_addr[0]; assign b1.cpu_addr = c_addr[1];
  assign b0.cpu_din = c_din[0];   assign b1.cpu_din = c_din[1];
  assign b0.host_req = h_req[0];  assign b1.host_req = h_req[1];
  assign b0.host_write = h_wr[0]; assign b1.host_write = h_wr[1];
  assign b0.host_addr = h_addr[0]; assign b1.host_addr = h_addr[1];
  assign b0.host_din = h_din[0];  assign b1.host_din = h_din[1];
  assign b0.host_lock = h_lock[0]; assign b1.host_lock = h_lock[1];

  assign o_cg[0] = b0.cpu_gnt;     assign o_cg[1] = b1.cpu_gnt;
  assign o_hg[0] = b0.host_gnt;    assign o_hg[1] = b1.host_gnt;
  assign o_cv[0] = b0.cpu_rvalid;  assign o_cv[1] = b1.cpu_rvalid;
  assign o_hv[0] = b0.host_rvalid; assign o_hv[1] = b1.host_rvalid;
  assign o_cd[0] = b0.cpu_dout;    assign o_cd[1] = b1.cpu_dout;
  assign o_hd[0] = b0.host_dout;   assign o_hd[1] = b1.host_dout;
  assign o_la[0] = b0.lock_ack;    assign o_la[1] = b1.lock_ack;
  assign o_rw[0] = b0.ram_write;   assign o_rw[1] = b1.ram_write;
  assign o_ra[0] = b0.ram_addr;    assign o_ra[1] = b1.ram_addr;

  // RAM models: unwritten locations read as addr^0x3C, except addr 5 = 0x2A.
  logic [7:0] mem [2][256];
  bit         wf  [2][256];
  logic [7:0] rd0, rd1a, rd1b;

  function automatic logic [7:0] dflt(input logic [7:0] a);
    return (a == 8'h05) ? 8'h2A : (a ^ 8'h3C);
  endfunction

  always @(posedge clk) begin
    if (b0.ram_write) begin
      mem[0][b0.ram_addr] <= b0.ram_din;
      wf[0][b0.ram_addr]  <= 1'b1;
    end
    if (b1.ram_write) begin
      mem[1][b1.ram_addr] <= b1.ram_din;
      wf[1][b1.ram_addr]  <= 1'b1;
    end
    rd0  <= wf[0][b0.ram_addr] ? mem[0][b0.ram_addr] : dflt(b0.ram_addr);
    rd1a <= wf[1][b1.ram_addr] ? mem[1][b1.ram_addr] : dflt(b1.ram_addr);
    rd1b <= rd1a;
  end
  assign b0.ram_dout = rd0;
  assign b1.ram_dout = rd1b;

  typedef struct {
    int         due;
    logic       host;
    logic [7:0] data;
  } exp_t;
  typedef exp_t exp_q_t[$];
  exp_q_t sbq [2];

  function automatic void push(input int d, input logic host, input logic [7:0] data);
    exp_t e;
    e.due  = cyc + ((d == 0) ? 1 : 2);
    e.host = host;
    e.data = data;
    sbq[d].push_back(e);
  endfunction

  task automatic check1(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s @cyc %0d: got %0b, required %0b", name, cyc, act, req);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s @cyc %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
    end
  endtask

  // Read-return monitor: every rvalid must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (o_cv[d] === 1'b1 || o_hv[d] === 1'b1) begin
          exp_t e;
          tests++;
          if (sbq[d].size() == 0) begin
            failed++;
            $display("FAIL unexpected_rvalid dut%0d @cyc %0d: cpu_rvalid=%0b host_rvalid=%0b, required none",
                     d, cyc, o_cv[d], o_hv[d]);
          end else begin
            e = sbq[d].pop_front();
            if (o_hv[d] !== e.host || o_cv[d] !== !e.host || cyc != e.due ||
                (e.host ? o_hd[d] : o_cd[d]) !== e.data) begin
              failed++;
              $display("FAIL read_return dut%0d: got host=%0b cpu=%0b data=0x%0h cyc=%0d, required host=%0b data=0x%0h cyc=%0d",
                       d, o_hv[d], o_cv[d], (e.host ? o_hd[d] : o_cd[d]), cyc, e.host, e.data, e.due);
            end
          end
        end
      end
    end
  end

  task automatic clr(input int d);
    c_req[d] = 1'b0; c_wr[d] = 1'b0; c_addr[d] = 8'h00; c_din[d] = 8'h00;
    h_req[d] = 1'b0; h_wr[d] = 1'b0; h_addr[d] = 8'h00; h_din[d] = 8'h00;
    h_lock[d] = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset(input int d);
    clr(d);
    rst_v[d] = 1'b1;
    nxt();
    nxt();
    rst_v[d] = 1'b0;
  endtask

  logic [3:0] order;

  initial begin
    for (int d = 0; d < 2; d++) begin
      clr(d);
      rst_v[d] = 1'b1;
    end
    // During reset: grant follows RR, ram_write is held low, returns are idle.
    c_req[0] = 1'b1; c_wr[0] = 1'b1; c_addr[0] = 8'h44; c_din[0] = 8'h99;
    mid();
    check1("rst_cpu_gnt", o_cg[0], 1'b1);
    check1("rst_ram_write", o_rw[0], 1'b0);
    check8("rst_ram_addr", o_ra[0], 8'h44);
    check1("rst_lock_ack", o_la[0], 1'b0);
    for (int d = 0; d < 2; d++) begin
      check1("rst_cpu_rvalid", o_cv[d], 1'b0);
      check1("rst_host_rvalid", o_hv[d], 1'b0);
      check8("rst_cpu_dout", o_cd[d], 8'h00);
      check8("rst_host_dout", o_hd[d], 8'h00);
    end
    clr(0);
    nxt();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // LATENCY=1 single CPU read of addr 5.
    c_req[0] = 1'b1; c_addr[0] = 8'h05;
    push(0, 1'b0, 8'h2A);
    mid();
    check1("rd_cpu_gnt", o_cg[0], 1'b1);
    check1("rd_host_gnt", o_hg[0], 1'b0);
    check8("rd_ram_addr", o_ra[0], 8'h05);
    check1("rd_ram_write", o_rw[0], 1'b0);
    nxt();
    clr(0);
    mid();
    check1("rd_cpu_rvalid", o_cv[0], 1'b1);
    check1("rd_host_rvalid", o_hv[0], 1'b0);
    check8("rd_host_dout_idle", o_hd[0], 8'h00);

    // Round-robin with both requesting right after reset: C, H, C, H.
    do_reset(0);
    order = 4'b1010;   // bit k = 1 means host wins cycle k
    c_req[0] = 1'b1; c_addr[0] = 8'h10;
    h_req[0] = 1'b1; h_addr[0] = 8'h20;
    for (int k = 0; k < 4; k++) begin
      mid();
      check1("rr_cpu_gnt", o_cg[0], !order[k]);
      check1("rr_host_gnt", o_hg[0], order[k]);
      check1("rr_ram_write", o_rw[0], 1'b0);
      push(0, order[k], order[k] ? 8'h1C : 8'h2C);
      nxt();
    end
    clr(0);
    nxt();

    // Lock, host writes 0x11 to 0..3 while the CPU keeps requesting.
    c_req[0] = 1'b1; c_addr[0] = 8'h30;
    h_lock[0] = 1'b1; h_req[0] = 1'b1; h_wr[0] = 1'b1; h_din[0] = 8'h11;
    for (int k = 0; k < 4; k++) begin
      h_addr[0] = 8'(k);
      mid();
      check1("lk_cpu_gnt", o_cg[0], 1'b0);
      check1("lk_host_gnt", o_hg[0], 1'b1);
      check1("lk_ram_write", o_rw[0], 1'b1);
      check1("lk_lock_ack", o_la[0], (k >= 2));
      nxt();
    end
    // Drop the lock: still LOCKED this cycle, then the CPU wins first.
    h_lock[0] = 1'b0; h_wr[0] = 1'b0; h_addr[0] = 8'h03; c_addr[0] = 8'h02;
    mid();
    check1("ul_host_gnt0", o_hg[0], 1'b1);
    check1("ul_cpu_gnt0", o_cg[0], 1'b0);
    push(0, 1'b1, 8'h11);
    nxt();
    mid();
    check1("ul_cpu_gnt1", o_cg[0], 1'b1);
    check1("ul_host_gnt1", o_hg[0], 1'b0);
    check8("ul_ram_addr1", o_ra[0], 8'h02);
    check1("ul_lock_ack1", o_la[0], 1'b0);
    push(0, 1'b0, 8'h11);
    nxt();
    mid();
    check1("ul_host_gnt2", o_hg[0], 1'b1);
    push(0, 1'b1, 8'h11);
    nxt();
    clr(0);

    // LATENCY=2: CPU read, then lock request while it is in flight.
    do_reset(1);
    c_req[1] = 1'b1; c_addr[1] = 8'h07;
    mid();
    check1("l2_cpu_gnt0", o_cg[1], 1'b1);
    push(1, 1'b0, 8'h3B);
    nxt();
    h_lock[1] = 1'b1; h_req[1] = 1'b1; h_addr[1] = 8'h08;
    mid();
    check1("l2_cpu_gnt1", o_cg[1], 1'b0);
    check1("l2_host_gnt1", o_hg[1], 1'b1);
    check1("l2_lock_ack1", o_la[1], 1'b0);
    push(1, 1'b1, 8'h34);
    nxt();
    h_addr[1] = 8'h09;
    mid();
    check1("l2_cpu_gnt2", o_cg[1], 1'b0);
    check1("l2_host_gnt2", o_hg[1], 1'b1);
    check1("l2_lock_ack2", o_la[1], 1'b0);
    check1("l2_cpu_rvalid2", o_cv[1], 1'b1);
    push(1, 1'b1, 8'h35);
    nxt();
    h_addr[1] = 8'h0A;
    mid();
    check1("l2_cpu_gnt3", o_cg[1], 1'b0);
    check1("l2_host_gnt3", o_hg[1], 1'b1);
    check1("l2_lock_ack3", o_la[1], 1'b1);
    push(1, 1'b1, 8'h36);
    nxt();
    c_req[1] = 1'b0; h_req[1] = 1'b0;
    nxt();
    nxt();
    h_lock[1] = 1'b0;
    nxt();

    // Reset one cycle after a granted host read discards it.
    h_lock[1] = 1'b1; h_req[1] = 1'b1; h_addr[1] = 8'h0C;
    mid();
    check1("rs_host_gnt", o_hg[1], 1'b1);
    nxt();
    clr(1);
    rst_v[1] = 1'b1;
    mid();
    check1("rs_lock_ack_in", o_la[1], 1'b0);
    check1("rs_host_rvalid_in", o_hv[1], 1'b0);
    nxt();
    rst_v[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      check1("rs_host_rvalid", o_hv[1], 1'b0);
      check1("rs_lock_ack", o_la[1], 1'b0);
      nxt();
    end
    c_req[1] = 1'b1; c_addr[1] = 8'h05;
    h_req[1] = 1'b1; h_addr[1] = 8'h06;
    mid();
    check1("rs_cpu_first", o_cg[1], 1'b1);
    push(1, 1'b0, 8'h2A);
    nxt();
    clr(1);

    for (int k = 0; k < 4; k++) nxt();
    tests++;
    if (sbq[0].size() != 0) begin
      failed++;
      $display("FAIL sb_drain dut0: %0d reads outstanding, required 0", sbq[0].size());
    end
    tests++;
    if (sbq[1].size() != 0) begin
      failed++;
      $display("FAIL sb_drain dut1: %0d reads outstanding, required 0", sbq[1].size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter W, default 8: address width, $clog2(RAM depth).
REQ-002 Parameter W_DATA, default 8: RAM data width.
REQ-003 Parameter LATENCY, default 1: RAM read latency in cycles; legal values 1 and 2 only.
REQ-004 The block SHALL have one clock, clk; reset is asynchronous and active-high, port rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 cpu_req  input  1  CPU access request.
REQ-008 cpu_write  input  1  1 = write, 0 = read; qualified by cpu_req.
REQ-009 cpu_addr  input  W  CPU address.
REQ-010 cpu_din  input  W_DATA  CPU write data.
REQ-011 cpu_gnt  output  1  CPU access accepted this cycle.
REQ-012 cpu_rvalid  output  1  CPU read data valid.
REQ-013 cpu_dout  output  W_DATA  CPU read data.
REQ-014 host_req, host_write, host_addr, host_din, host_gnt, host_rvalid, host_dout: same directions, widths and meanings as the cpu_* ports, for the loader/debug host.
REQ-015 host_lock  input  1  host requests exclusive RAM ownership.
REQ-016 lock_ack  output  1  exclusive ownership held and the CPU is quiescent.
REQ-017 ram_write  output  1  RAM write enable.
REQ-018 ram_addr  output  W  RAM address.
REQ-019 ram_din  output  W_DATA  RAM write data.
REQ-020 ram_dout  input  W_DATA  RAM read data, valid LATENCY cycles after the address is presented.

Function
REQ-021 At most one of cpu_gnt and host_gnt SHALL be 1 in any cycle; a grant is combinational from the req inputs, the arbitration state and the priority pointer.
REQ-022 ram_addr, ram_din and ram_write SHALL follow the granted requester combinationally; ram_write = granted requester's write bit; with no grant ram_write = 0 and ram_addr/ram_din = 0.
REQ-023 In state RR, the sole requester SHALL be granted; if both request, the requester not granted most recently wins (round-robin pointer updated on every grant).
REQ-024 A granted read SHALL enter a LATENCY-deep shift register carrying {valid, owner}; exactly LATENCY cycles later the owner's rvalid = 1 and its dout = ram_dout.
REQ-025 cpu_dout/host_dout SHALL be 0 whenever the corresponding rvalid = 0.
REQ-026 Granted writes SHALL NOT produce rvalid.
REQ-027 FSM states: RR, LOCK_PEND, LOCKED.
REQ-028 RR -> LOCK_PEND when host_lock = 1; the CPU receives no grant in the transition cycle or after it.
REQ-029 LOCK_PEND -> LOCKED when no CPU-owned read remains in the shift register; the exit condition is evaluated in that cycle.
REQ-030 In LOCK_PEND and LOCKED, cpu_gnt = 0 and host_req is granted every cycle; in-flight CPU reads still return normally.
REQ-031 lock_ack SHALL be 1 only in LOCKED, registered.
REQ-032 LOCK_PEND or LOCKED -> RR when host_lock = 0; in the first RR cycle after a lock the CPU has priority.
REQ-033 The round-robin pointer SHALL NOT change while in LOCK_PEND or LOCKED.
REQ-034 Back-to-back grants every cycle SHALL be sustained; there are no bubbles between reads.

Reset
REQ-035 While rst = 1: state = RR, pointer gives the CPU first priority, shift register cleared, lock_ack = 0, both rvalid = 0, both dout = 0.
REQ-036 Reset asserted mid-operation SHALL discard in-flight reads; no rvalid is asserted for them after reset releases.
REQ-037 gnt and ram_* outputs SHALL follow REQ-021/022 from state RR during reset; ram_write is forced to 0 while rst = 1.

Verification
REQ-038 LATENCY=1: CPU read addr 0x05 with RAM[5]=0x2A -> cpu_gnt in cycle 0, cpu_rvalid=1 and cpu_dout=0x2A in cycle 1, host_rvalid=0.
REQ-039 Both requesters request continuously for 4 cycles after reset -> grant order CPU, host, CPU, host; ram_write never set for reads.
REQ-040 LATENCY=2: CPU read in cycle 0, host_lock raised in cycle 1 with host_req -> state LOCK_PEND; cpu_rvalid in cycle 2; lock_ack=1 in cycle 3; host granted in cycles 1-3.
REQ-041 LOCKED, host writes 0x11 to addr 0x00..0x03 with cpu_req=1 held -> cpu_gnt=0 throughout; after host_lock drops, the CPU is granted in the first cycle.
REQ-042 rst pulsed one cycle after a granted host read with LATENCY=2 -> host_rvalid stays 0, lock_ack=0, state RR.
